// File: rtl/ram_port_ctrl.sv
// Request-driven initiator for the two-read/one-write RAM: latches a write+dual-read
// request, sequences write phase then read phase, captures both results and returns them.
module ram_port_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_waddr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_raddr1,
  input  logic [ADDR_W-1:0] req_raddr2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic [15:0]       txn_count,
  output logic              ram_ce,
  output logic              ram_rr,
  output logic [ADDR_W-1:0] ram_in_data_1_sel,
  output logic [ADDR_W-1:0] ram_out_data_1_sel,
  output logic [ADDR_W-1:0] ram_out_data_2_sel,
  output logic [DATA_W-1:0] ram_in_data_1,
  input  logic [DATA_W-1:0] ram_out_data_1,
  input  logic [DATA_W-1:0] ram_out_data_2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CAP,
    S_RSP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_raddr1;
  logic [ADDR_W-1:0] r_raddr2;
  logic [DATA_W-1:0] r_rsp_data1;
  logic [DATA_W-1:0] r_rsp_data2;
  logic [15:0]       r_txn_count;
  logic              w_accept;
  logic              w_done;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_done   = rsp_ready && (r_state == S_RSP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_raddr1    <= '0;
      r_raddr2    <= '0;
      r_rsp_data1 <= '0;
      r_rsp_data2 <= '0;
      r_txn_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_waddr  <= req_waddr;
        r_wdata  <= req_wdata;
        r_raddr1 <= req_raddr1;
        r_raddr2 <= req_raddr2;
      end
      // RAM read data is registered, so it is valid during CAP, one cycle after RD
      if (r_state == S_CAP) begin
        r_rsp_data1 <= ram_out_data_1;
        r_rsp_data2 <= ram_out_data_2;
      end
      if (w_done) begin
        r_txn_count <= r_txn_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_next             = r_state;
    req_ready          = 1'b0;
    rsp_valid          = 1'b0;
    ram_ce             = 1'b0;
    ram_rr             = 1'b0;
    ram_in_data_1_sel  = '0;
    ram_in_data_1      = '0;
    ram_out_data_1_sel = '0;
    ram_out_data_2_sel = '0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_WR;
      end
      S_WR: begin
        ram_ce            = r_we;
        ram_in_data_1_sel = r_waddr;
        ram_in_data_1     = r_wdata;
        w_next            = S_RD;
      end
      S_RD: begin
        ram_ce             = 1'b1;
        ram_rr             = 1'b1;
        ram_out_data_1_sel = r_raddr1;
        ram_out_data_2_sel = r_raddr2;
        w_next             = S_CAP;
      end
      S_CAP: begin
        w_next = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign rsp_data1 = r_rsp_data1;
  assign rsp_data2 = r_rsp_data2;
  assign txn_count = r_txn_count;

endmodule
